// File: rtl/lsnn_spike_encoder_if.sv
// Intensity-load handshake between host and spike encoder.
// Host drives channel/value; encoder answers with ready while idle.
interface lsnn_spike_encoder_if #(
  parameter int CHANNELS = 8,
  parameter int VAL_W    = 8
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic            load_valid;
  logic            load_ready;
  logic [CH_W-1:0] load_ch;
  logic [VAL_W-1:0] load_val;

  modport master (
    output load_valid,
    output load_ch,
    output load_val,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_ch,
    input  load_val,
    output load_ready
  );
endinterface

// File: rtl/lsnn_spike_encoder.sv
// Rate-coded spike transmitter: per-channel sigma-delta accumulators
// run over a fixed window of timesteps, feeding the LSNN spike bus.
module lsnn_spike_encoder #(
  parameter int CHANNELS = 8,
  parameter int VAL_W    = 8,
  parameter int WINDOW   = 16,
  parameter int STEP_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  lsnn_spike_encoder_if.slave load,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic                step_strobe,
  output logic [CHANNELS-1:0] spike_out
);
  localparam int DIV_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int STEP_W = $clog2(WINDOW + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]  div_q;
  logic [STEP_W-1:0] step_q;
  logic [VAL_W-1:0]  inten_q [CHANNELS];
  logic [VAL_W-1:0]  acc_q   [CHANNELS];
  logic [VAL_W-1:0]  acc_nxt [CHANNELS];
  logic [CHANNELS-1:0] spike_nxt;
  logic [CHANNELS-1:0] spike_q;
  logic done_q;
  logic strobe_q;
  logic fire;
  logic finish;
  logic wr_en;

  // Step math is done one cycle early so the strobe comes out registered
  // in the last cycle of each timestep.
  assign fire = (state_q == RUN) && !stop
              && (div_q == DIV_W'(STEP_DIV - 2));

  assign finish = (state_q == RUN) && !stop
                && (div_q == DIV_W'(STEP_DIV - 1))
                && (step_q == STEP_W'(WINDOW));

  assign wr_en = load.load_valid && (state_q == IDLE)
               && (int'(load.load_ch) < CHANNELS);

  always_comb begin
    spike_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      logic [VAL_W:0] sum;
      sum = {1'b0, acc_q[i]} + {1'b0, inten_q[i]};
      spike_nxt[i] = sum[VAL_W];
      acc_nxt[i]   = sum[VAL_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (stop || finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      spike_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        inten_q[i] <= '0;
        acc_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      done_q   <= finish;
      strobe_q <= fire;
      spike_q  <= fire ? spike_nxt : '0;
      if (wr_en) inten_q[load.load_ch] <= load.load_val;
      if (state_q == IDLE && start) begin
        div_q  <= '0;
        step_q <= '0;
        for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      end else if (state_q == RUN) begin
        if (div_q == DIV_W'(STEP_DIV - 1)) div_q <= '0;
        else div_q <= div_q + 1'b1;
        if (fire) begin
          step_q <= step_q + 1'b1;
          for (int i = 0; i < CHANNELS; i++) acc_q[i] <= acc_nxt[i];
        end
      end
    end
  end

  assign load.load_ready = (state_q == IDLE);
  assign busy            = (state_q == RUN);
  assign done            = done_q;
  assign step_strobe     = strobe_q;
  assign spike_out       = spike_q;
endmodule

// File: doc/lsnn_spike_encoder.md
Name: lsnn_spike_encoder

Overview:
Rate-coded spike train transmitter that drives the 8-bit spike input bus of tt_um_LSNN (ui_in). A host loads per-channel intensity values through a valid/ready handshake. On start, the block runs a per-channel sigma-delta accumulator for a fixed window of timesteps and emits one-cycle spike pulses whose count is proportional to intensity. It is the input-side counterpart of the LSNN, which receives spikes; this block generates them.

Parameters:
CHANNELS, 8, number of spike channels (width of spike_out; matches ui_in).
VAL_W, 8, intensity width in bits; accumulator modulus is 2^VAL_W.
WINDOW, 16, timesteps per run (>=1).
STEP_DIV, 4, clk cycles per timestep (>=2).

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
load_valid  input  1  host offers an intensity write.
load_ready  output  1  block accepts writes; equals (state==IDLE).
load_ch  input  clog2(CHANNELS)  target channel index.
load_val  input  VAL_W  intensity for load_ch.
start  input  1  begin a run (sampled in IDLE only).
stop  input  1  abort a run (sampled in RUN only).
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse on normal run completion.
step_strobe  output  1  one-cycle pulse marking each timestep.
spike_out  output  CHANNELS  spike vector, valid only while step_strobe=1; otherwise 0.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; all intensity registers, accumulators, and counters = 0; busy=0, done=0, step_strobe=0, spike_out=0; load_ready=1 from the next cycle. Reset during RUN aborts immediately with no done pulse.
- States: IDLE -> RUN -> IDLE. There is no separate DONE state; done is a registered pulse.
- IDLE: a write occurs at an edge where load_valid & load_ready; intensity[load_ch] <= load_val. Writes with load_ch >= CHANNELS are accepted and discarded. Intensities persist across runs until overwritten or reset.
- start=1 in IDLE at edge t -> RUN. If load_valid is also asserted at edge t, that write completes and its value is used in the run. At edge t: accumulators cleared to 0, div_cnt=0, step_cnt=0.
- RUN: busy=1 in cycles t+1 .. t+WINDOW*STEP_DIV. load_ready=0. start is ignored.
- Timestep k (k=1..WINDOW): step_strobe=1 and spike_out valid in exactly cycle t+k*STEP_DIV.
  - Per channel: sum = acc + intensity, computed (VAL_W+1) bits wide.
  - spike_out[i] = sum[VAL_W].
  - acc <= sum[VAL_W-1:0].
- Total spikes per channel per run = floor(intensity*WINDOW / 2^VAL_W). Spikes are evenly spaced (sigma-delta).
- After step WINDOW: done=1 for exactly cycle t+WINDOW*STEP_DIV+1. busy=0 in that same cycle and the state returns to IDLE.
- A start sampled in the done cycle is honoured and launches a new run.
- stop=1 at any RUN edge: return to IDLE next cycle with busy=0 and no done pulse. The step scheduled for that edge is suppressed (no strobe). Intensities are retained.
- stop and rst in IDLE: stop ignored; rst as above.
- Counters wrap-safe: div_cnt is clog2(STEP_DIV) bits; step_cnt is clog2(WINDOW+1) bits. Neither overflows.

Test Plan:
- Reset/defaults: assert rst for 2 cycles -> busy=0, done=0, spike_out=0, step_strobe=0, load_ready=1. Start with no loads -> 16 strobes, all spike_out=0, done at t+65.
- Full-scale and half-scale: load ch0=255, ch1=128, ch7=0; start -> ch0 spikes on 15 of 16 steps (silent on step 1 only); ch1 spikes on steps 2,4,…,16 (8 total); ch7 never spikes. busy high exactly 64 cycles, one done pulse.
- Handshake edges: load_valid during RUN -> load_ready=0 and value unchanged. start+load(ch2=64) in the same IDLE cycle -> ch2 spikes on steps 4,8,12,16.
- Abort: start with ch0=255, assert stop after 3 strobes -> exactly 3 strobes, busy falls next cycle, no done. Restart -> full 15 spikes (accumulators re-cleared).
- Reset mid-run: rst at step 5 -> outputs zero next cycle. Restart without loads -> no spikes (intensities cleared).
- Back-to-back: start asserted in the done cycle -> second run begins with busy high the following cycle and an identical spike pattern.
